// File: rtl/alu_seq_ctrl.sv
// Multi-cycle Moore sequencer for the shared 16-bit datapath: latches one
// decoded instruction per start request and drives every datapath enable.
module alu_seq_ctrl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       w,
   output logic       err,
   output logic [2:0] nsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       vsel,
   output logic       write,
   output logic [1:0] alu_op
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WIMM,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_CMP,
      S_WB
   } state_t;

   localparam logic [4:0] I_MOV_IMM = 5'b110_10;
   localparam logic [4:0] I_MOV_REG = 5'b110_00;
   localparam logic [4:0] I_ADD     = 5'b101_00;
   localparam logic [4:0] I_CMP     = 5'b101_01;
   localparam logic [4:0] I_AND     = 5'b101_10;
   localparam logic [4:0] I_MVN     = 5'b101_11;

   state_t     state_q, state_d;
   logic [4:0] instr_q, instr_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_WAIT;
         instr_q <= 5'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   // The instruction is captured only when leaving WAIT; everything after
   // that decodes from instr_q so the decoder may move on freely.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      case (state_q)
         S_WAIT: begin
            if (s) begin
               instr_d = {opcode, op};
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (instr_q)
               I_MOV_IMM:               state_d = S_WIMM;
               I_MOV_REG, I_MVN:        state_d = S_GET_B;
               I_ADD, I_AND, I_CMP:     state_d = S_GET_A;
               default:                 state_d = S_WAIT;
            endcase
         end
         S_WIMM:  state_d = S_WAIT;
         S_GET_A: state_d = S_GET_B;
         S_GET_B: state_d = (instr_q == I_CMP) ? S_CMP : S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_CMP:   state_d = S_WAIT;
         S_WB:    state_d = S_WAIT;
         default: state_d = S_WAIT;
      endcase
   end

   always_comb begin
      w      = 1'b0;
      err    = 1'b0;
      nsel   = 3'b000;
      loada  = 1'b0;
      loadb  = 1'b0;
      loadc  = 1'b0;
      loads  = 1'b0;
      asel   = 1'b0;
      bsel   = 1'b0;
      vsel   = 1'b0;
      write  = 1'b0;
      alu_op = 2'b00;
      case (state_q)
         S_WAIT: w = 1'b1;
         S_DECODE: begin
            err = !(instr_q inside {I_MOV_IMM, I_MOV_REG, I_ADD, I_CMP, I_AND, I_MVN});
         end
         S_WIMM: begin
            nsel  = 3'b001;
            vsel  = 1'b1;
            write = 1'b1;
         end
         S_GET_A: begin
            nsel  = 3'b001;
            loada = 1'b1;
         end
         S_GET_B: begin
            nsel  = 3'b100;
            loadb = 1'b1;
         end
         S_EXEC: begin
            // MOV reg reuses the adder as a pass-through: C = 0 + B.
            loadc = 1'b1;
            if (instr_q == I_MOV_REG) begin
               asel   = 1'b1;
               alu_op = 2'b00;
            end else begin
               alu_op = instr_q[1:0];
            end
         end
         S_CMP: begin
            alu_op = 2'b01;
            loads  = 1'b1;
         end
         S_WB: begin
            nsel  = 3'b010;
            write = 1'b1;
         end
         default: w = 1'b0;
      endcase
   end

endmodule
